// File: rtl/spi_slave_7seg.sv
// SPI mode-0 slave oversampled in the clk domain; shows the last byte and a byte
// count in hex on an 8-digit active-low seven-segment bank.
module spi_slave_7seg #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       sclk_i,
  input  logic       mosi_i,
  input  logic       cs_n_i,
  input  logic [7:0] tx_data_i,
  output logic       miso_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       frame_err_o,
  output logic       busy_o,
  output logic [6:0] seg_o [7:0],
  output logic [7:0] led_data_o
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_s, mosi_s, cs_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       got_byte_q, got_byte_d;
  logic       rx_valid_q, rx_valid_d;
  logic       frame_err_q, frame_err_d;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // cs_n chain resets low: a frame already running at release never shows a fall
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
      state_q     <= IDLE;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      byte_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      got_byte_q  <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      state_q     <= state_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      byte_cnt_q  <= byte_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      got_byte_q  <= got_byte_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    byte_cnt_d  = byte_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    got_byte_d  = got_byte_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d    = ACTIVE;
          bit_cnt_d  = '0;
          got_byte_d = 1'b0;
          tx_shift_d = tx_data_i;
        end
      end
      ACTIVE: begin
        if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[6:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d  = {rx_shift_q[6:0], mosi_s};
            rx_valid_d = 1'b1;
            byte_cnt_d = byte_cnt_q + 8'd1;
            got_byte_d = 1'b1;
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q != 3'd0) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end else if (got_byte_q) begin
            tx_shift_d = tx_data_i;
          end
        end
        // Judged on the post-rise count so a byte finishing on this edge is kept
        if (cs_rise) begin
          state_d     = IDLE;
          frame_err_d = (bit_cnt_d != 3'd0);
          bit_cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign seg_o[0] = hex7(rx_data_q[3:0]);
  assign seg_o[1] = hex7(rx_data_q[7:4]);
  assign seg_o[2] = hex7(byte_cnt_q[3:0]);
  assign seg_o[3] = hex7(byte_cnt_q[7:4]);

  generate
    for (genvar gi = 4; gi < 8; gi++) begin : g_blank
      assign seg_o[gi] = 7'h7F;
    end
  endgenerate

  assign miso_o      = (state_q == ACTIVE) ? tx_shift_q[7] : 1'b0;
  assign busy_o      = (state_q == ACTIVE);
  assign rx_data_o   = rx_data_q;
  assign led_data_o  = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_spi_slave_7seg.sv
// Bench for spi_slave_7seg: bit-banged SPI master, event-scheduled reference model
// compared every cycle, directed scenarios with literal expectations, random frames.
module tb_spi_slave_7seg;
  localparam int S = 2;
  localparam int EV_CSF = 0, EV_MISO = 1, EV_RX = 2, EV_CSR = 3;

  logic       clk_i, rst_n_i, sclk_i, mosi_i, cs_n_i;
  logic [7:0] tx_data_i;
  logic       miso_o, rx_valid_o, frame_err_o, busy_o;
  logic [7:0] rx_data_o, led_data_o;
  logic [6:0] seg_o [7:0];

  spi_slave_7seg #(.SYNC_STAGES(S)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .sclk_i(sclk_i), .mosi_i(mosi_i),
    .cs_n_i(cs_n_i), .tx_data_i(tx_data_i), .miso_o(miso_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .frame_err_o(frame_err_o),
    .busy_o(busy_o), .seg_o(seg_o), .led_data_o(led_data_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {int due; int kind; logic [7:0] val;} ev_t;
  ev_t evq[$];

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_chk = 0, n_fail = 0, cyc = 0, rv_pulses = 0, fe_pulses = 0;
  logic [7:0] m_rx, m_cnt;
  logic       m_busy, m_miso;
  logic [7:0] mo_b [5];
  logic [7:0] tx_b [5];
  logic [7:0] got [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    evq.delete();
    m_rx = 8'h00; m_cnt = 8'h00; m_busy = 1'b0; m_miso = 1'b0;
  endtask

  // Pin change driven now is sampled next edge and acted on S edges later
  task automatic sched(input int kind, input logic [7:0] val);
    ev_t e;
    e.due = cyc + 1 + S; e.kind = kind; e.val = val;
    evq.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    ev_t e;
    logic exp_rv, exp_fe;
    model_clear();
    forever begin
      @(posedge clk_i);
      cyc++;
      #3;
      exp_rv = 1'b0; exp_fe = 1'b0;
      while (evq.size() > 0 && evq[0].due <= cyc) begin
        e = evq.pop_front();
        case (e.kind)
          EV_CSF:  begin m_busy = 1'b1; m_miso = e.val[0]; end
          EV_MISO: m_miso = e.val[0];
          EV_RX:   begin m_rx = e.val; m_cnt = m_cnt + 8'd1; exp_rv = 1'b1; end
          default: begin m_busy = 1'b0; m_miso = 1'b0; exp_fe = e.val[0]; end
        endcase
      end
      chk("rx_valid", rx_valid_o, exp_rv);
      chk("frame_err", frame_err_o, exp_fe);
      chk("busy", busy_o, m_busy);
      chk("miso", miso_o, m_miso);
      chk("rx_data", rx_data_o, m_rx);
      chk("led_data", led_data_o, m_rx);
      chk("seg0", seg_o[0], hex_tab[m_rx[3:0]]);
      chk("seg1", seg_o[1], hex_tab[m_rx[7:4]]);
      chk("seg2", seg_o[2], hex_tab[m_cnt[3:0]]);
      chk("seg3", seg_o[3], hex_tab[m_cnt[7:4]]);
      for (int i = 4; i < 8; i++) chk($sformatf("seg%0d", i), seg_o[i], 7'h7F);
      if (rx_valid_o) rv_pulses++;
      if (frame_err_o) fe_pulses++;
    end
  end

  // Master: nbytes full bytes then `extra` loose bits; half period h clk cycles.
  task automatic send_frame(input int nbytes, input int extra, input int h, input bit abort);
    int total, byi, bi;
    logic [7:0] cur_tx;
    total = nbytes * 8 + extra;
    tx_data_i = tx_b[0];
    cur_tx = tx_b[0];
    mosi_i = mo_b[0][7];
    cs_n_i = 1'b0;
    sched(EV_CSF, {7'b0, cur_tx[7]});
    wait_cyc(h);
    for (int b = 0; b < total; b++) begin
      byi = b / 8; bi = b % 8;
      got[byi][7-bi] = miso_o;
      sclk_i = 1'b1;
      if (bi == 7) begin
        sched(EV_RX, mo_b[byi]);
        tx_data_i = tx_b[byi+1];
      end
      wait_cyc(h);
      sclk_i = 1'b0;
      if (bi != 7) begin
        sched(EV_MISO, {7'b0, cur_tx[6-bi]});
      end else begin
        cur_tx = tx_data_i;
        sched(EV_MISO, {7'b0, cur_tx[7]});
      end
      if (b + 1 < total) mosi_i = mo_b[(b+1)/8][7-((b+1)%8)];
      wait_cyc(h);
    end
    $display("frame: %0d bytes + %0d bits, half-period %0d, first byte %02h%s",
             nbytes, extra, h, mo_b[0], abort ? " (aborted by reset)" : "");
    if (!abort) begin
      cs_n_i = 1'b1;
      sched(EV_CSR, {7'b0, (total % 8) != 0});
      wait_cyc(h);
    end
  endtask

  task automatic do_reset(input bit hold_cs);
    rst_n_i = 1'b0;
    model_clear();
    #1;
    chk("rst_now_rx", rx_data_o, 8'h00);
    chk("rst_now_led", led_data_o, 8'h00);
    chk("rst_now_busy", busy_o, 1'b0);
    chk("rst_now_miso", miso_o, 1'b0);
    chk("rst_now_seg2", seg_o[2], 7'h40);
    wait_cyc(3);
    sclk_i = 1'b0;
    if (!hold_cs) cs_n_i = 1'b1;
    rst_n_i = 1'b1;
    if (hold_cs) begin
      repeat (2) begin
        wait_cyc(3); sclk_i = 1'b1; mosi_i = ~mosi_i;
        wait_cyc(3); sclk_i = 1'b0;
      end
      wait_cyc(3);
      cs_n_i = 1'b1;
    end
    wait_cyc(6);
  endtask

  initial begin
    int rv0, fe0, nb, ex;
    logic [7:0] led0;
    logic [6:0] s2_0, s3_0;
    rst_n_i = 1'b0; cs_n_i = 1'b1; sclk_i = 1'b0; mosi_i = 1'b0; tx_data_i = 8'h00;
    for (int i = 0; i < 5; i++) begin mo_b[i] = 8'h00; tx_b[i] = 8'h00; got[i] = 8'h00; end
    wait_cyc(5);
    rst_n_i = 1'b1;
    wait_cyc(20);
    for (int i = 0; i < 4; i++) chk($sformatf("idle_seg%0d", i), seg_o[i], 7'h40);
    for (int i = 4; i < 8; i++) chk($sformatf("idle_seg%0d", i), seg_o[i], 7'h7F);
    chk("idle_rx", rx_data_o, 8'h00);
    chk("idle_busy", busy_o, 1'b0);

    // Single byte A5 in, 5A out, sclk = clk/8
    mo_b[0] = 8'hA5; tx_b[0] = 8'h5A; tx_b[1] = 8'h00;
    rv0 = rv_pulses;
    send_frame(1, 0, 4, 1'b0);
    wait_cyc(4);
    chk("t1_rv_pulses", rv_pulses - rv0, 1);
    chk("t1_rx", rx_data_o, 8'hA5);
    chk("t1_led", led_data_o, 8'hA5);
    chk("t1_seg0", seg_o[0], 7'h12);
    chk("t1_seg1", seg_o[1], 7'h08);
    chk("t1_seg2", seg_o[2], 7'h79);
    chk("t1_miso_byte", got[0], 8'h5A);

    // Back-to-back bytes with tx reload
    do_reset(1'b0);
    mo_b[0] = 8'hA5; mo_b[1] = 8'h3C; tx_b[0] = 8'h5A; tx_b[1] = 8'hC3; tx_b[2] = 8'h00;
    rv0 = rv_pulses;
    send_frame(2, 0, 4, 1'b0);
    wait_cyc(4);
    chk("t2_rv_pulses", rv_pulses - rv0, 2);
    chk("t2_rx", rx_data_o, 8'h3C);
    chk("t2_seg0", seg_o[0], 7'h46);
    chk("t2_seg1", seg_o[1], 7'h30);
    chk("t2_seg2", seg_o[2], 7'h24);
    chk("t2_miso_b0", got[0], 8'h5A);
    chk("t2_miso_b1", got[1], 8'hC3);

    // Partial byte then a good one
    led0 = led_data_o; s2_0 = seg_o[2]; s3_0 = seg_o[3];
    rv0 = rv_pulses; fe0 = fe_pulses;
    mo_b[0] = 8'hF0;
    send_frame(0, 4, 4, 1'b0);
    wait_cyc(2);
    chk("t3_fe_pulses", fe_pulses - fe0, 1);
    chk("t3_rv_pulses", rv_pulses - rv0, 0);
    chk("t3_led_kept", led_data_o, led0);
    chk("t3_seg2_kept", seg_o[2], s2_0);
    chk("t3_seg3_kept", seg_o[3], s3_0);
    mo_b[0] = 8'h3C; tx_b[0] = 8'h96;
    send_frame(1, 0, 4, 1'b0);
    wait_cyc(2);
    chk("t3_rx_after", rx_data_o, 8'h3C);
    chk("t3_rv_after", rv_pulses - rv0, 1);
    chk("t3_miso_byte", got[0], 8'h96);

    // Reset 5 bits into a frame, cs_n still low at release
    mo_b[0] = 8'hFF;
    send_frame(0, 5, 4, 1'b1);
    chk("t4_busy_before", busy_o, 1'b1);
    do_reset(1'b1);
    mo_b[0] = 8'h81; tx_b[0] = 8'h24;
    send_frame(1, 0, 4, 1'b0);
    wait_cyc(2);
    chk("t4_rx", rx_data_o, 8'h81);
    chk("t4_seg2", seg_o[2], 7'h79);
    chk("t4_seg3", seg_o[3], 7'h40);

    // Random frames, with occasional idle sclk/mosi noise
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat (3) begin
          sclk_i = 1'b1; mosi_i = 1'($urandom); wait_cyc(3);
          sclk_i = 1'b0; wait_cyc(3);
        end
      end
      nb = $urandom_range(0, 3);
      ex = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      if (nb == 0 && ex == 0) nb = 1;
      for (int i = 0; i < 5; i++) begin mo_b[i] = 8'($urandom); tx_b[i] = 8'($urandom); end
      send_frame(nb, ex, $urandom_range(S + 1, 6), 1'b0);
      for (int i = 0; i < nb; i++) chk($sformatf("rnd_miso_b%0d", i), got[i], tx_b[i]);
    end

    // Counter wrap after 256 single-byte frames
    do_reset(1'b0);
    for (int f = 0; f < 256; f++) begin
      mo_b[0] = 8'($urandom); tx_b[0] = 8'($urandom); tx_b[1] = 8'($urandom);
      send_frame(1, 0, S + 1, 1'b0);
    end
    wait_cyc(2);
    chk("wrap_model_cnt", m_cnt, 8'h00);
    chk("wrap_seg2", seg_o[2], 7'h40);
    chk("wrap_seg3", seg_o[3], 7'h40);
    chk("wrap_rx", rx_data_o, mo_b[0]);

    wait_cyc(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_slave_7seg.md
# spi_slave_7seg

SPI Mode-0 slave that receives 8-bit MSB-first bytes from the board's SPI master and returns a byte on `miso`. Each received byte is shown on `led_data` and on the 8-digit seven-segment bank: the hex value of the last byte and a received-byte count. All SPI pins are sampled into the single system clock domain, and no logic runs on `sclk`.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth for `sclk`, `mosi` and `cs_n` (legal range ≥2).
- `clk` input 1: system clock, all state on its rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `sclk` input 1: SPI clock from master, idles low (CPOL=0).
- `mosi` input 1: master-out data.
- `cs_n` input 1: active-low chip select, frames transfers.
- `tx_data` input 8: byte to return; loaded at frame start and at each byte boundary.
- `miso` output 1: slave-out data, MSB first; 0 when deselected.
- `rx_data` output 8: last complete received byte.
- `rx_valid` output 1: one-cycle pulse when `rx_data` updates.
- `frame_err` output 1: one-cycle pulse when `cs_n` rises with a partial byte.
- `busy` output 1: high while the synchronized `cs_n` is low.
- `seg` output 8×7 (`[6:0] seg [7:0]`): digit patterns, active-low, bit order {g,f,e,d,c,b,a}.
- `led_data` output 8: mirror of `rx_data`.

## Operation
- Synchronizers: `SYNC_STAGES` flops per input. One extra register per signal holds the previous synchronized value for edge detection.
- States:
  - IDLE (sync `cs_n`=1) → ACTIVE on the detected `cs_n` fall.
  - ACTIVE → IDLE on the detected `cs_n` rise.
- Entering ACTIVE:
  - `bit_cnt`←0.
  - `tx_shift`←`tx_data`; `miso` presents `tx_data[7]` immediately.
- ACTIVE, `sclk` rising edge detected:
  - `rx_shift`←{`rx_shift[6:0]`,`mosi_s`}; `bit_cnt`++.
  - When this is bit 8: `rx_data`←the assembled byte, `rx_valid`←1, `bit_cnt`←0, `byte_cnt`++ (8-bit, wraps 255→0).
- ACTIVE, `sclk` falling edge detected:
  - If `bit_cnt`≠0: `tx_shift`←{`tx_shift[6:0]`,0}.
  - If `bit_cnt`=0 and at least one byte has been completed in this frame: `tx_shift`←`tx_data`. This is back-to-back reload.
- `miso`=`tx_shift[7]` in ACTIVE, 0 in IDLE.
- `cs_n` rise in ACTIVE:
  - If `bit_cnt`≠0: pulse `frame_err` and discard the partial byte. `rx_data`, `led_data`, `byte_cnt` and `seg` are unchanged.
  - `bit_cnt`←0 in all cases.
- `sclk` and `mosi` activity in IDLE is ignored.
- Display:
  - `seg[0]` = hex of `rx_data[3:0]`; `seg[1]` = hex of `rx_data[7:4]`.
  - `seg[2]` = hex of `byte_cnt[3:0]`; `seg[3]` = hex of `byte_cnt[7:4]`.
  - `seg[7:4]` = 7'h7F (blank).
  - Hex codes 0–F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E. Decoders are combinational from registered values.
- Reset values:
  - `miso`=0, `rx_data`=0, `led_data`=0, `rx_valid`=0, `frame_err`=0, `busy`=0.
  - `byte_cnt`=0, state=IDLE.
  - `seg[3:0]`=7'h40, `seg[7:4]`=7'h7F.
- Reset mid-frame: immediate return to reset values. After release, the block waits in IDLE for a fresh `cs_n` fall. A frame already in progress (`cs_n` low at release) is not joined; this is covered by requiring a detected fall.

## Timing
- `sclk` high and low phases must each be ≥ `SYNC_STAGES`+1 `clk` periods. `cs_n` setup to the first `sclk` rise and hold after the last `sclk` fall must also be ≥ `SYNC_STAGES`+1 `clk` periods.
- Edge detection latency: a pin transition sampled at `clk` edge k is acted on at edge k+`SYNC_STAGES`.
- `rx_valid`, `rx_data`, `led_data` and `byte_cnt` all update on the same edge, `SYNC_STAGES` cycles after the 8th `sclk` rise is first sampled. `seg` follows in the same cycle.
- `miso` changes `SYNC_STAGES` cycles after the `sclk` fall or `cs_n` fall. This is valid before the master's next rising sample given the phase constraint above.
- `frame_err` and the `busy` fall occur on the same edge as the detected `cs_n` rise.
- A `cs_n` rise detected on the same edge as the 8th `sclk` rise (illegal timing) is handled as byte complete: `rx_valid`=1, `frame_err`=0.

## Test plan
- Reset, then idle 20 cycles → all outputs at reset values; `seg[0]`=`seg[1]`=`seg[2]`=`seg[3]`=7'h40; `seg[7:4]`=7'h7F.
- One frame, `mosi`=0xA5, `tx_data`=0x5A, `sclk`=clk/8 → `rx_valid` single pulse; `rx_data`=`led_data`=0xA5; `seg[0]`=7'h12, `seg[1]`=7'h08, `seg[2]`=7'h79; `miso` bits 0,1,0,1,1,0,1,0 at master sample points.
- One frame of two bytes 0xA5, 0x3C, with `tx_data` changed to 0xC3 after the first `rx_valid` → two `rx_valid` pulses; final `rx_data`=0x3C; `seg[1:0]`=7'h30,7'h46; byte count=2; `miso` returns 0x5A then 0xC3.
- `cs_n` raised after 4 bits → `frame_err` one pulse, no `rx_valid`; `led_data` and count unchanged. The next full byte 0x3C is received correctly.
- `rst_n` asserted after 5 bits of a frame → outputs at reset values immediately. Subsequent full frame 0x81 → `rx_data`=0x81, count=1.
- 256 single-byte frames → count wraps to 0x00; `seg[3:2]`=7'h40,7'h40.
